// File: rtl/csr_trap_unit.sv
// Machine-mode CSR file with an external-interrupt trap sequencer.
// CSR updates are committed at retirement; INTR is synchronised before qualification.
module csr_trap_unit #(
  parameter logic [31:0] MTVEC_RST   = 32'h0000_0000,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        INTR,
  input  logic [11:0] CSR_ADDR,
  input  logic        CSR_WE,
  input  logic [31:0] CSR_WD,
  output logic [31:0] CSR_RD,
  input  logic        MRET_EXEC,
  input  logic        PIPE_ACK,
  input  logic [31:0] ACK_PC,
  output logic        INT_REQ,
  output logic        INT_TAKEN,
  output logic [31:0] MTVEC,
  output logic [31:0] MEPC
);

  if (SYNC_STAGES < 2 || SYNC_STAGES > 3) begin : g_bad_sync_stages
    $error("SYNC_STAGES must be 2 or 3");
  end

  localparam logic [11:0] AddrMstatus = 12'h300;
  localparam logic [11:0] AddrMie     = 12'h304;
  localparam logic [11:0] AddrMtvec   = 12'h305;
  localparam logic [11:0] AddrMepc    = 12'h341;
  localparam logic [11:0] AddrMcause  = 12'h342;

  localparam logic [31:0] MstatusMask = 32'h0000_0088;
  localparam logic [31:0] MieMask     = 32'h0000_0800;
  localparam logic [31:0] AlignMask   = 32'hFFFF_FFFC;
  localparam logic [31:0] CauseExtInt = 32'h8000_000B;

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StReq  = 2'd1;
  localparam logic [1:0] StTrap = 2'd2;

  logic [SYNC_STAGES-1:0] sync_q;
  logic [1:0]             state_q, state_d;
  logic [31:0]            ack_pc_q, ack_pc_d;
  logic [31:0]            mstatus_q, mstatus_d;
  logic [31:0]            mie_q, mie_d;
  logic [31:0]            mtvec_q, mtvec_d;
  logic [31:0]            mepc_q, mepc_d;
  logic [31:0]            mcause_q, mcause_d;
  logic                   pending;

  assign pending = sync_q[SYNC_STAGES-1] & mstatus_q[3] & mie_q[11];

  always_comb begin
    state_d  = state_q;
    ack_pc_d = ack_pc_q;
    case (state_q)
      StIdle: if (pending && !MRET_EXEC) state_d = StReq;
      StReq: begin
        if (!pending) begin
          state_d = StIdle;
        end else if (PIPE_ACK) begin
          state_d  = StTrap;
          ack_pc_d = ACK_PC;
        end
      end
      StTrap:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Later assignments win: software write < mret < trap entry.
  always_comb begin
    mstatus_d = mstatus_q;
    mie_d     = mie_q;
    mtvec_d   = mtvec_q;
    mepc_d    = mepc_q;
    mcause_d  = mcause_q;
    if (CSR_WE) begin
      case (CSR_ADDR)
        AddrMstatus: mstatus_d = CSR_WD & MstatusMask;
        AddrMie:     mie_d     = CSR_WD & MieMask;
        AddrMtvec:   mtvec_d   = CSR_WD & AlignMask;
        AddrMepc:    mepc_d    = CSR_WD & AlignMask;
        AddrMcause:  mcause_d  = CSR_WD;
        default:     ;
      endcase
    end
    if (MRET_EXEC) begin
      mstatus_d = {24'h0, 1'b1, 3'b000, mstatus_q[7], 3'b000};
    end
    if (state_q == StTrap) begin
      mepc_d    = ack_pc_q & AlignMask;
      mcause_d  = CauseExtInt;
      mstatus_d = {24'h0, mstatus_q[3], 7'h00};
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      sync_q    <= '0;
      state_q   <= StIdle;
      ack_pc_q  <= '0;
      mstatus_q <= '0;
      mie_q     <= '0;
      mtvec_q   <= MTVEC_RST;
      mepc_q    <= '0;
      mcause_q  <= '0;
    end else begin
      sync_q    <= {sync_q[SYNC_STAGES-2:0], INTR};
      state_q   <= state_d;
      ack_pc_q  <= ack_pc_d;
      mstatus_q <= mstatus_d;
      mie_q     <= mie_d;
      mtvec_q   <= mtvec_d;
      mepc_q    <= mepc_d;
      mcause_q  <= mcause_d;
    end
  end

  always_comb begin
    case (CSR_ADDR)
      AddrMstatus: CSR_RD = mstatus_q;
      AddrMie:     CSR_RD = mie_q;
      AddrMtvec:   CSR_RD = mtvec_q;
      AddrMepc:    CSR_RD = mepc_q;
      AddrMcause:  CSR_RD = mcause_q;
      default:     CSR_RD = 32'h0;
    endcase
  end

  assign INT_REQ   = (state_q == StReq);
  assign INT_TAKEN = (state_q == StTrap);
  assign MTVEC     = mtvec_q;
  assign MEPC      = mepc_q;

endmodule

// File: tb/tb_csr_trap_unit.sv
// Directed plus randomized bench for csr_trap_unit against a word-level behavioural model.
module tb_csr_trap_unit;

  localparam logic [31:0] MtvecRst   = 32'h0000_2000;
  localparam int unsigned SyncStages = 2;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        INTR = 1'b0;
  logic [11:0] CSR_ADDR = 12'h0;
  logic        CSR_WE = 1'b0;
  logic [31:0] CSR_WD = 32'h0;
  logic [31:0] CSR_RD;
  logic        MRET_EXEC = 1'b0;
  logic        PIPE_ACK = 1'b0;
  logic [31:0] ACK_PC = 32'h0;
  logic        INT_REQ;
  logic        INT_TAKEN;
  logic [31:0] MTVEC;
  logic [31:0] MEPC;

  csr_trap_unit #(
    .MTVEC_RST  (MtvecRst),
    .SYNC_STAGES(SyncStages)
  ) dut (
    .CLK      (CLK),
    .RST      (RST),
    .INTR     (INTR),
    .CSR_ADDR (CSR_ADDR),
    .CSR_WE   (CSR_WE),
    .CSR_WD   (CSR_WD),
    .CSR_RD   (CSR_RD),
    .MRET_EXEC(MRET_EXEC),
    .PIPE_ACK (PIPE_ACK),
    .ACK_PC   (ACK_PC),
    .INT_REQ  (INT_REQ),
    .INT_TAKEN(INT_TAKEN),
    .MTVEC    (MTVEC),
    .MEPC     (MEPC)
  );

  always #5 CLK = ~CLK;

  int vectors = 0;
  int miscompares = 0;

  // Behavioural model: whole-word CSR values, an INTR history line, two flags for the sequence.
  logic        m_valid = 1'b0;
  logic [31:0] m_mstatus, m_mie, m_mtvec, m_mepc, m_mcause, m_ackpc;
  logic        m_req, m_taken;
  logic        m_hist [SyncStages];

  function automatic logic [31:0] model_read(input logic [11:0] a);
    case (a)
      12'h300: return m_mstatus;
      12'h304: return m_mie;
      12'h305: return m_mtvec;
      12'h341: return m_mepc;
      12'h342: return m_mcause;
      default: return 32'h0;
    endcase
  endfunction

  task automatic model_step();
    logic [31:0] o_mstatus;
    logic        pending;
    logic        was_taken;
    if (RST) begin
      m_valid = 1'b1;
      m_mstatus = 0; m_mie = 0; m_mtvec = MtvecRst; m_mepc = 0; m_mcause = 0; m_ackpc = 0;
      m_req = 0; m_taken = 0;
      for (int i = 0; i < SyncStages; i++) m_hist[i] = 1'b0;
      return;
    end
    o_mstatus = m_mstatus;
    pending   = m_hist[SyncStages-1] && o_mstatus[3] && m_mie[11];
    was_taken = m_taken;
    if (CSR_WE) begin
      if (CSR_ADDR == 12'h300) m_mstatus = CSR_WD & 32'h88;
      if (CSR_ADDR == 12'h304) m_mie = CSR_WD & 32'h800;
      if (CSR_ADDR == 12'h305) m_mtvec = CSR_WD - (CSR_WD % 4);
      if (CSR_ADDR == 12'h341) m_mepc = CSR_WD - (CSR_WD % 4);
      if (CSR_ADDR == 12'h342) m_mcause = CSR_WD;
    end
    if (MRET_EXEC) m_mstatus = 32'h80 + (o_mstatus[7] ? 32'h8 : 32'h0);
    if (was_taken) begin
      m_mepc    = m_ackpc - (m_ackpc % 4);
      m_mcause  = 32'h8000_000B;
      m_mstatus = o_mstatus[3] ? 32'h80 : 32'h0;
      m_taken   = 0;
    end else if (m_req) begin
      if (!pending) m_req = 0;
      else if (PIPE_ACK) begin
        m_req = 0; m_taken = 1; m_ackpc = ACK_PC;
      end
    end else if (pending && !MRET_EXEC) begin
      m_req = 1;
    end
    for (int i = SyncStages - 1; i > 0; i--) m_hist[i] = m_hist[i-1];
    m_hist[0] = INTR;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Settle combinational outputs after input changes, then compare against the model.
  task automatic apply();
    #1;
    if (m_valid) begin
      check("int_req", {31'h0, INT_REQ}, {31'h0, m_req});
      check("int_taken", {31'h0, INT_TAKEN}, {31'h0, m_taken});
      check("mtvec", MTVEC, m_mtvec);
      check("mepc", MEPC, m_mepc);
      check("csr_rd", CSR_RD, model_read(CSR_ADDR));
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    model_step();
    @(negedge CLK);
  endtask

  task automatic rd(input logic [11:0] a, input logic [31:0] exp, input string name);
    CSR_ADDR = a;
    apply();
    check(name, CSR_RD, exp);
  endtask

  task automatic wr(input logic [11:0] a, input logic [31:0] d);
    CSR_WE = 1'b1; CSR_ADDR = a; CSR_WD = d;
    apply();
    tick();
    CSR_WE = 1'b0;
  endtask

  logic [11:0] addrs [7] = '{12'h300, 12'h304, 12'h305, 12'h341, 12'h342, 12'h7C0, 12'h301};

  initial begin
    // 1: reset values
    tick(); tick();
    RST = 1'b0;
    rd(12'h300, 32'h0, "rst_mstatus");
    rd(12'h304, 32'h0, "rst_mie");
    rd(12'h305, MtvecRst, "rst_mtvec");
    tick();
    rd(12'h341, 32'h0, "rst_mepc");
    rd(12'h342, 32'h0, "rst_mcause");
    rd(12'h7C0, 32'h0, "rst_unimpl");
    tick();

    // 2: write masking
    wr(12'h305, 32'h0000_0103);
    wr(12'h300, 32'hFFFF_FFFF);
    rd(12'h305, 32'h0000_0100, "mtvec_align");
    rd(12'h300, 32'h0000_0088, "mstatus_mask");
    tick();
    wr(12'h304, 32'hFFFF_FFFF);
    rd(12'h304, 32'h0000_0800, "mie_mask");

    // 3: interrupt entry latency and trap
    INTR = 1'b1;
    for (int k = 1; k <= SyncStages + 1; k++) begin
      tick();
      apply();
      check("req_latency", {31'h0, INT_REQ}, {31'h0, k == SyncStages + 1});
    end
    tick(); apply(); check("req_hold", {31'h0, INT_REQ}, 32'h1);
    tick(); apply(); check("req_hold2", {31'h0, INT_REQ}, 32'h1);
    PIPE_ACK = 1'b1; ACK_PC = 32'h0000_0044;
    apply();
    tick();
    PIPE_ACK = 1'b0; ACK_PC = 32'hDEAD_BEEF;
    apply();
    check("taken_pulse", {31'h0, INT_TAKEN}, 32'h1);
    check("req_in_trap", {31'h0, INT_REQ}, 32'h0);
    tick();
    apply();
    check("taken_single", {31'h0, INT_TAKEN}, 32'h0);
    check("trap_mepc", MEPC, 32'h0000_0044);
    rd(12'h342, 32'h8000_000B, "trap_mcause");
    rd(12'h300, 32'h0000_0080, "trap_mstatus");

    // 4: mret restores MIE; INTR still high re-requests
    MRET_EXEC = 1'b1;
    apply();
    tick();
    MRET_EXEC = 1'b0;
    rd(12'h300, 32'h0000_0088, "mret_mstatus");
    check("mret_mepc", MEPC, 32'h0000_0044);
    tick();
    apply();
    check("rereq", {31'h0, INT_REQ}, 32'h1);

    // 5: clearing mie while requesting withdraws the request
    wr(12'h304, 32'h0);
    apply();
    tick();
    apply();
    check("withdraw_req", {31'h0, INT_REQ}, 32'h0);
    check("withdraw_taken", {31'h0, INT_TAKEN}, 32'h0);
    check("withdraw_mepc", MEPC, 32'h0000_0044);

    // 6: reset during the trap cycle
    wr(12'h304, 32'h800);
    tick();
    apply();
    check("req_again", {31'h0, INT_REQ}, 32'h1);
    PIPE_ACK = 1'b1; ACK_PC = 32'h0000_0123;
    apply();
    tick();
    PIPE_ACK = 1'b0;
    apply();
    check("taken_again", {31'h0, INT_TAKEN}, 32'h1);
    RST = 1'b1;
    tick();
    RST = 1'b0;
    apply();
    check("rst_trap_taken", {31'h0, INT_TAKEN}, 32'h0);
    check("rst_trap_mepc", MEPC, 32'h0);
    rd(12'h342, 32'h0, "rst_trap_mcause");
    rd(12'h300, 32'h0, "rst_trap_mstatus");
    tick();

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      RST       = ($urandom_range(0, 99) == 0);
      if ($urandom_range(0, 7) == 0) INTR = ~INTR;
      CSR_WE    = ($urandom_range(0, 3) == 0);
      CSR_ADDR  = addrs[$urandom_range(0, 6)];
      CSR_WD    = $urandom();
      if ($urandom_range(0, 1) == 0) CSR_WD = CSR_WD | 32'h0000_0888;
      MRET_EXEC = ($urandom_range(0, 15) == 0);
      PIPE_ACK  = ($urandom_range(0, 2) == 0);
      ACK_PC    = $urandom();
      apply();
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/csr_trap_unit.md
Name: csr_trap_unit

Overview:
- Machine-mode CSR file and external-interrupt trap sequencer for the pipelined core.
- Executes the CSR write-back that the control decoder requests for csrrw/csrrs/csrrc, and services mret.
- Produces the int_taken indication the decoder and fetch consume, plus the mtvec/mepc redirect targets.
- Sits beside the writeback stage; all CSR updates happen at retirement.

Parameters:
- MTVEC_RST, 32'h0000_0000, reset value of mtvec.
- SYNC_STAGES, 2, flip-flop synchroniser depth on INTR (allowed range 2..3).

Ports:
- CLK in 1: system clock, rising edge.
- RST in 1: synchronous, active-high reset.
- INTR in 1: asynchronous external interrupt, level-sensitive.
- CSR_ADDR in 12: CSR address (IR[31:20]) of the instruction in writeback.
- CSR_WE in 1: CSR write strobe from writeback; the instruction is retiring this cycle.
- CSR_WD in 32: new CSR value, i.e. the ALU result: rs1 for csrrw, or/and for csrrs/csrrc.
- CSR_RD out 32: combinational read of CSR_ADDR; 0 for unimplemented addresses.
- MRET_EXEC in 1: mret retiring this cycle.
- PIPE_ACK in 1: pipeline has drained for a trap request.
- ACK_PC in 32: PC of the next unexecuted instruction; valid with PIPE_ACK.
- INT_REQ out 1: trap request to the hazard unit (stall fetch, drain pipeline).
- INT_TAKEN out 1: one-cycle pulse; fetch selects MTVEC.
- MTVEC out 32: trap vector.
- MEPC out 32: return address for mret.

Behaviour:
- Implemented CSRs:
  - mstatus 0x300: only bit3 MIE and bit7 MPIE are writable; all other bits read 0.
  - mie 0x304: only bit11 MEIE is writable.
  - mtvec 0x305: bits[1:0] are forced to 0 on write.
  - mepc 0x341: bits[1:0] are forced to 0 on write.
  - mcause 0x342: full 32 bits.
  - Writes to any other address are ignored.
- Reset values: mstatus=0, mie=0, mtvec=MTVEC_RST, mepc=0, mcause=0, synchroniser flops=0, state=IDLE, INT_REQ=0, INT_TAKEN=0.
- CSR writes: take effect on the CLK edge where CSR_WE=1. CSR_RD reflects the new value the following cycle. There is no read-during-write bypass; forwarding is the pipeline's responsibility.
- Interrupt qualifier: INTR passes through SYNC_STAGES flops giving intr_s, so latency from INTR to eligibility is SYNC_STAGES cycles. pending = intr_s & MIE & MEIE.
- State machine:
  - IDLE: INT_REQ=0. Go to REQ when pending=1 and MRET_EXEC=0.
  - REQ: INT_REQ=1.
    - If pending drops (a CSR write cleared MIE/MEIE, or INTR deasserted), return to IDLE with no trap.
    - Else if PIPE_ACK=1, go to TRAP.
    - PIPE_ACK is ignored outside REQ.
  - TRAP: lasts one cycle, then always returns to IDLE.
    - INT_TAKEN=1 and INT_REQ=0.
    - On the exiting edge: mepc<=ACK_PC captured on the REQ->TRAP edge with bits[1:0]=0; mcause<=32'h8000_000B; MPIE<=MIE; MIE<=0.
- mret (MRET_EXEC=1, any state): MIE<=MPIE and MPIE<=1. MEPC output is unchanged. An mret in IDLE blocks the IDLE->REQ transition for that cycle only.
- Priorities on the same edge:
  - Trap-entry updates override a CSR_WE write to mstatus, mepc or mcause. CSR_WE writes to mie and mtvec still apply.
  - mret overrides a CSR_WE write to mstatus.
  - mret and TRAP together cannot occur legally (the pipeline is drained); if they do, trap updates win.
- After a trap, MIE=0, so nested interrupts are impossible until mret or a software set of MIE.
- A still-asserted INTR re-requests after mret restores MIE.
- Reset has priority over everything. RST mid-REQ or mid-TRAP forces IDLE with all outputs at their reset values; no partial CSR update occurs.

Test Plan:
1. Reset, then read all five addresses, then read 0x7C0.
   -> CSR_RD = 0, 0, MTVEC_RST, 0, 0; 0x7C0 reads 0.
2. Write mtvec=32'h0000_0103 and mstatus=32'hFFFF_FFFF.
   -> mtvec reads 32'h0000_0100; mstatus reads 32'h0000_0088.
3. MIE=1 and MEIE=1, raise INTR. Assert PIPE_ACK 3 cycles after INT_REQ with ACK_PC=32'h0000_0044.
   -> INT_REQ rises SYNC_STAGES+1 cycles after INTR.
   -> INT_TAKEN is a single pulse the cycle after ACK.
   -> mepc=32'h44, mcause=32'h8000_000B, mstatus=32'h80.
4. Continuing from 3, pulse MRET_EXEC with INTR still high.
   -> mstatus=32'h88 next cycle; INT_REQ reasserts the following cycle.
5. In REQ, write mie=0 via CSR_WE before any ACK.
   -> INT_REQ drops next cycle, returns to IDLE, no INT_TAKEN, mepc unchanged.
6. Assert RST in the TRAP cycle.
   -> INT_TAKEN=0, mepc=0, mcause=0, mstatus=0 on the next cycle.
